// File: rtl/uart_fifo_sync_if.sv
// Bus-side signal bundle of uart_fifo_sync: write/read handshakes, levels and status.
// The master drives requests and thresholds; the FIFO (slave) drives data and flags.
interface uart_fifo_sync_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 8
);
    logic             CLEAR;
    logic             WE;
    logic [WIDTH-1:0] DATA;
    logic             RE;
    logic [WIDTH-1:0] Q;
    logic [AW:0]      AFULL_LEVEL;
    logic [AW:0]      AEMPTY_LEVEL;
    logic [AW:0]      COUNT;
    logic             FULL;
    logic             EMPTY;
    logic             AFULL;
    logic             AEMPTY;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output CLEAR, WE, DATA, RE, AFULL_LEVEL, AEMPTY_LEVEL,
        input  Q, COUNT, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  CLEAR, WE, DATA, RE, AFULL_LEVEL, AEMPTY_LEVEL,
        output Q, COUNT, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/uart_fifo_sync.sv
// Single-clock parametrised FIFO for the CoreUART Tx/Rx paths, with occupancy count,
// programmable almost-full/empty levels, error pulses, flush and optional FWFT read.
module uart_fifo_sync #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    parameter  int FWFT  = 0,
    localparam int AW    = $clog2(DEPTH)
) (
    input logic             CLOCK,
    input logic             RESET,
    uart_fifo_sync_if.slave bus
);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             full, empty;
    logic             rd_acc, wr_acc, wr_en;
    logic [WIDTH-1:0] head;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign head  = mem_q[rptr_q];

    always_comb begin
        rd_acc  = bus.RE && !empty;
        // A read frees the slot in the same edge, so a write to a full FIFO still lands.
        wr_acc  = bus.WE && (!full || rd_acc);
        wr_en   = wr_acc && !bus.CLEAR;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        q_d     = q_q;

        if (bus.CLEAR) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + AW'(1);
            if (rd_acc) rptr_d = rptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
            ovf_d = bus.WE && !wr_acc;
            udf_d = bus.RE && !rd_acc;
        end

        // FWFT keeps a shadow of the presented word so Q holds once the FIFO drains.
        if (FWFT != 0) begin
            if (!empty) q_d = head;
        end else if (rd_acc && !bus.CLEAR) begin
            q_d = head;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (wr_en) mem_q[wptr_q] <= bus.DATA;
    end

    assign bus.Q         = ((FWFT != 0) && !empty) ? head : q_q;
    assign bus.COUNT     = count_q;
    assign bus.FULL      = full;
    assign bus.EMPTY     = empty;
    assign bus.AFULL     = (count_q >= bus.AFULL_LEVEL);
    assign bus.AEMPTY    = (count_q <= bus.AEMPTY_LEVEL);
    assign bus.OVERFLOW  = ovf_q;
    assign bus.UNDERFLOW = udf_q;
endmodule

// File: tb/tb_uart_fifo_sync.sv
// Directed bench for uart_fifo_sync: a 256x8 standard-mode instance and a 4x12 FWFT
// instance share clock and reset; expected values are hand-derived or from a queue.
module tb_uart_fifo_sync;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    uart_fifo_sync_if #(.WIDTH(8),  .AW(8)) ia ();
    uart_fifo_sync_if #(.WIDTH(12), .AW(2)) ib ();

    uart_fifo_sync #(.WIDTH(8), .DEPTH(256), .FWFT(0)) u_std (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (ia)
    );

    uart_fifo_sync #(.WIDTH(12), .DEPTH(4), .FWFT(1)) u_fwft (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (ib)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] data;
        logic [8:0] count;
        logic       empty;
        logic       ovf;
        logic       udf;
        logic [7:0] q;
    } vec_t;

    vec_t vt [8];

    function automatic vec_t mk(input logic we, input logic re, input logic [7:0] d,
                                input logic [8:0] c, input logic e, input logic o,
                                input logic u, input logic [7:0] q);
        vec_t v;
        v.we = we; v.re = re; v.data = d; v.count = c;
        v.empty = e; v.ovf = o; v.udf = u; v.q = q;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] sb [$];
    logic [11:0] last_b;
    logic [7:0]  exp8;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ia.CLEAR = 1'b0; ia.WE = 1'b0; ia.RE = 1'b0; ia.DATA = '0;
        ia.AFULL_LEVEL = 9'd192; ia.AEMPTY_LEVEL = 9'd4;
        ib.CLEAR = 1'b0; ib.WE = 1'b0; ib.RE = 1'b0; ib.DATA = '0;
        ib.AFULL_LEVEL = 3'd3; ib.AEMPTY_LEVEL = 3'd1;

        // empty-boundary table: simultaneous WE/RE on empty, underflow, hold of Q
        vt[0] = mk(1'b1, 1'b1, 8'h11, 9'd1, 1'b0, 1'b0, 1'b1, 8'h00);
        vt[1] = mk(1'b0, 1'b0, 8'h00, 9'd1, 1'b0, 1'b0, 1'b0, 8'h00);
        vt[2] = mk(1'b0, 1'b1, 8'h00, 9'd0, 1'b1, 1'b0, 1'b0, 8'h11);
        vt[3] = mk(1'b0, 1'b1, 8'h00, 9'd0, 1'b1, 1'b0, 1'b1, 8'h11);
        vt[4] = mk(1'b1, 1'b0, 8'h22, 9'd1, 1'b0, 1'b0, 1'b0, 8'h11);
        vt[5] = mk(1'b1, 1'b1, 8'h33, 9'd1, 1'b0, 1'b0, 1'b0, 8'h22);
        vt[6] = mk(1'b0, 1'b1, 8'h00, 9'd0, 1'b1, 1'b0, 1'b0, 8'h33);
        vt[7] = mk(1'b0, 1'b0, 8'h00, 9'd0, 1'b1, 1'b0, 1'b0, 8'h33);

        #22;
        chk("rst_empty",  32'(ia.EMPTY),  32'd1);
        chk("rst_full",   32'(ia.FULL),   32'd0);
        chk("rst_aempty", 32'(ia.AEMPTY), 32'd1);
        chk("rst_afull",  32'(ia.AFULL),  32'd0);
        chk("rst_count",  32'(ia.COUNT),  32'd0);
        chk("rst_q",      32'(ia.Q),      32'd0);
        chk("rst_ovf",    32'(ia.OVERFLOW),  32'd0);
        chk("rst_udf",    32'(ia.UNDERFLOW), 32'd0);
        chk("rst_b_q",    32'(ib.Q),      32'd0);
        chk("rst_b_empty", 32'(ib.EMPTY), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            ia.WE = vt[i].we; ia.RE = vt[i].re; ia.DATA = vt[i].data;
            step();
            chk($sformatf("vec%0d_count", i), 32'(ia.COUNT),     32'(vt[i].count));
            chk($sformatf("vec%0d_empty", i), 32'(ia.EMPTY),     32'(vt[i].empty));
            chk($sformatf("vec%0d_ovf", i),   32'(ia.OVERFLOW),  32'(vt[i].ovf));
            chk($sformatf("vec%0d_udf", i),   32'(ia.UNDERFLOW), 32'(vt[i].udf));
            chk($sformatf("vec%0d_q", i),     32'(ia.Q),         32'(vt[i].q));
        end
        ia.WE = 1'b0; ia.RE = 1'b0;

        // fill 0x00..0xFF with threshold sweep along the way
        for (int i = 0; i < 256; i++) begin
            ia.WE = 1'b1; ia.DATA = 8'(i);
            step();
            if (i == 3)   chk("aempty_at4", 32'(ia.AEMPTY), 32'd1);
            if (i == 4)   chk("aempty_at5", 32'(ia.AEMPTY), 32'd0);
            if (i == 190) begin
                chk("afull_at191", 32'(ia.AFULL), 32'd0);
                ia.AFULL_LEVEL = 9'd100;
                #1;
                chk("afull_lvl100", 32'(ia.AFULL), 32'd1);
                ia.AFULL_LEVEL = 9'd192;
                #1;
                chk("afull_lvl192", 32'(ia.AFULL), 32'd0);
            end
            if (i == 191) chk("afull_at192", 32'(ia.AFULL), 32'd1);
            if (i == 254) chk("full_at255",  32'(ia.FULL),  32'd0);
        end
        chk("full_at256",  32'(ia.FULL),  32'd1);
        chk("count_256",   32'(ia.COUNT), 32'd256);
        ia.DATA = 8'hEE;
        step();
        chk("ovf_pulse",   32'(ia.OVERFLOW), 32'd1);
        chk("ovf_count",   32'(ia.COUNT),    32'd256);
        ia.WE = 1'b0;
        step();
        chk("ovf_one_cyc", 32'(ia.OVERFLOW), 32'd0);

        ia.WE = 1'b1; ia.RE = 1'b1; ia.DATA = 8'h5A;
        step();
        chk("wr_full_count", 32'(ia.COUNT),    32'd256);
        chk("wr_full_ovf",   32'(ia.OVERFLOW), 32'd0);
        chk("wr_full_q",     32'(ia.Q),        32'h00);
        ia.WE = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step();
            exp8 = (i < 255) ? 8'(i + 1) : 8'h5A;
            chk($sformatf("rd_q%0d", i), 32'(ia.Q), 32'(exp8));
        end
        chk("drain_empty", 32'(ia.EMPTY), 32'd1);
        chk("drain_count", 32'(ia.COUNT), 32'd0);
        ia.RE = 1'b0;
        step();

        // flush at 37 entries with concurrent WE/RE
        for (int i = 0; i < 37; i++) begin
            ia.WE = 1'b1; ia.DATA = 8'(8'h40 + i);
            step();
        end
        chk("pre_clr_count", 32'(ia.COUNT), 32'd37);
        ia.CLEAR = 1'b1; ia.RE = 1'b1; ia.DATA = 8'hFF;
        step();
        chk("clr_count", 32'(ia.COUNT),     32'd0);
        chk("clr_empty", 32'(ia.EMPTY),     32'd1);
        chk("clr_ovf",   32'(ia.OVERFLOW),  32'd0);
        chk("clr_udf",   32'(ia.UNDERFLOW), 32'd0);
        chk("clr_q",     32'(ia.Q),         32'h5A);
        ia.CLEAR = 1'b0; ia.WE = 1'b0; ia.RE = 1'b0;
        step();
        chk("post_clr_udf", 32'(ia.UNDERFLOW), 32'd0);
        ia.WE = 1'b1; ia.DATA = 8'h77;
        step();
        ia.WE = 1'b0; ia.RE = 1'b1;
        step();
        ia.RE = 1'b0;
        chk("post_clr_rd_q", 32'(ia.Q), 32'h77);
        chk("post_clr_cnt",  32'(ia.COUNT), 32'd0);

        // FWFT instance
        ib.WE = 1'b1; ib.DATA = 12'hABC;
        sb.push_back(12'hABC);
        step();
        chk("fwft_q_abc",  32'(ib.Q),     32'hABC);
        chk("fwft_empty0", 32'(ib.EMPTY), 32'd0);
        chk("fwft_count1", 32'(ib.COUNT), 32'd1);
        for (int k = 0; k < 3; k++) begin
            ib.DATA = 12'(12'h100 + k);
            sb.push_back(ib.DATA);
            step();
        end
        chk("fwft_full",  32'(ib.FULL),  32'd1);
        chk("fwft_afull", 32'(ib.AFULL), 32'd1);
        ib.RE = 1'b1;
        for (int j = 0; j < 40; j++) begin
            ib.DATA = 12'(12'h200 + j * 7);
            chk($sformatf("fwft_wrap%0d", j), 32'(ib.Q), 32'(sb[0]));
            step();
            void'(sb.pop_front());
            sb.push_back(ib.DATA);
        end
        chk("fwft_wrap_cnt", 32'(ib.COUNT),    32'd4);
        chk("fwft_wrap_ovf", 32'(ib.OVERFLOW), 32'd0);
        ib.WE = 1'b0;
        last_b = '0;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("fwft_drain%0d", j), 32'(ib.Q), 32'(sb[0]));
            last_b = sb[0];
            step();
            void'(sb.pop_front());
        end
        chk("fwft_empty1", 32'(ib.EMPTY), 32'd1);
        chk("fwft_hold",   32'(ib.Q),     32'(last_b));
        step();
        chk("fwft_hold2",  32'(ib.Q),     32'(last_b));
        chk("fwft_udf",    32'(ib.UNDERFLOW), 32'd1);

        // reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            ia.WE = 1'b1; ia.DATA = 8'(8'h91 + i);
            step();
        end
        ia.RE = 1'b1; ia.DATA = 8'hA5;
        step();
        chk("burst_q",   32'(ia.Q),     32'h91);
        chk("burst_cnt", 32'(ia.COUNT), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_count",  32'(ia.COUNT),     32'd0);
        chk("mrst_empty",  32'(ia.EMPTY),     32'd1);
        chk("mrst_full",   32'(ia.FULL),      32'd0);
        chk("mrst_aempty", 32'(ia.AEMPTY),    32'd1);
        chk("mrst_afull",  32'(ia.AFULL),     32'd0);
        chk("mrst_q",      32'(ia.Q),         32'd0);
        chk("mrst_ovf",    32'(ia.OVERFLOW),  32'd0);
        chk("mrst_b_udf",  32'(ib.UNDERFLOW), 32'd0);
        chk("mrst_b_q",    32'(ib.Q),         32'd0);
        #1;
        rst_n = 1'b1;
        ib.RE = 1'b0;
        ia.RE = 1'b0; ia.WE = 1'b1; ia.DATA = 8'hC3;
        step();
        chk("first_wr_cnt",   32'(ia.COUNT), 32'd1);
        chk("first_wr_empty", 32'(ia.EMPTY), 32'd0);
        ia.WE = 1'b0; ia.RE = 1'b1;
        step();
        ia.RE = 1'b0;
        chk("first_wr_q", 32'(ia.Q), 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
